window_shade_actuator: RTL and testbench
========================================

// Module: window_shade_actuator
// PURPOSE
//  Consumer end of the shade-level interface: takes a 4-bit target shade level from the shade-degree logic.
//  Drives the shade motor step by step until the tracked shade position equals the target.
//  Sits between the shade-degree decision logic and the motor driver pins of the smart-home system.
//  Level 0 = fully open, level 15 = fully closed.
// PARAMETERS
//  STEPS_PER_LEVEL  8  clock cycles of motor drive per one shade level (>=2)
//  SETTLE_CYCLES    4  motor-off dwell after reaching target, before done (>=1)
// PORTS
//  clk         in   1  single system clock, all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  cmd_valid   in   1  target level offered
//  cmd_level   in   4  target shade level 0..15
//  cmd_ready   out  1  high only in IDLE and not in reset; command accepted on cmd_valid&&cmd_ready
//  pos         out  4  current tracked shade level
//  busy        out  1  state != IDLE
//  done        out  1  one-cycle pulse when a command completes
//  motor_up    out  1  drive toward closed (level increasing)
//  motor_down  out  1  drive toward open (level decreasing)
//  motor_step  out  1  one-cycle pulse per level boundary crossed
// BEHAVIOUR
//  Reset: state=IDLE, pos=0, step_cnt=0, settle_cnt=0, done=0, motor_up=motor_down=motor_step=0, cmd_ready=0 while rst=1.
//  States: IDLE, MOVE, SETTLE.
//  IDLE, accept (edge N):
//   - Latch target and set dir=(cmd_level>pos).
//   - cmd_level==pos: stay IDLE, done=1 in cycle N+1, no motor activity.
//   - Otherwise enter MOVE at N+1, step_cnt=0.
//  MOVE:
//   - Exactly one of motor_up/motor_down is high, per dir; the other is 0.
//   - step_cnt counts 0..STEPS_PER_LEVEL-1.
//   - motor_step is high in the cycle where step_cnt==STEPS_PER_LEVEL-1.
//   - At that edge: pos+=1 (up) or pos-=1 (down), and step_cnt returns to 0.
//   - If the new pos==target, enter SETTLE with motors off.
//   - A move of d levels spends exactly d*STEPS_PER_LEVEL cycles in MOVE.
//  SETTLE:
//   - Motors off; settle_cnt counts to SETTLE_CYCLES-1, then IDLE.
//   - done is high in the first IDLE cycle, for one cycle only.
//  pos saturates by construction: it never wraps, since target is within 0..15 and moves are monotonic toward it.
//  Commands while busy: cmd_ready=0, cmd_valid ignored and not queued.
//  rst mid-MOVE/SETTLE:
//   - Abort immediately; all outputs at reset values next cycle.
//   - pos=0, i.e. the shade is re-homed as open by system convention.
//  motor_up&&motor_down is never 1. motor_step only pulses in MOVE.
// CONFIGURATION
//  Macro SHADE_LIMIT_SW_EN, when defined:
//   - Adds ports lim_top in 1, lim_bottom in 1 (synchronous, active-high) and lim_hit out 1.
//   - In MOVE up with lim_top=1: pos:=15, abort to SETTLE, lim_hit:=1.
//   - In MOVE down with lim_bottom=1: pos:=0, abort to SETTLE, lim_hit:=1.
//   - done still pulses after SETTLE.
//   - lim_hit is sticky; cleared on the next accepted command or on rst.
//   - The limit check takes priority over a motor_step in the same cycle.
//  Macro undefined: those ports and that logic are absent; pos is purely step-counted.
// STRUCTURE
//  Package shade_pkg:
//   - SHADE_W=4, SHADE_OPEN=4'h0, SHADE_CLOSED=4'hF.
//   - State encoding localparams IDLE/MOVE/SETTLE, shared with the shade-degree logic.
//  Sub-module shade_step_timer: a loadable down-counter with a terminal-count pulse.
//   - Reused for both the step timing and the settle dwell.
//  The FSM, pos register and motor outputs stay in window_shade_actuator.
// TESTING (STEPS_PER_LEVEL=8, SETTLE_CYCLES=4)
//  1. Reset held 3 cycles -> pos=0, busy=0, done=0, all motor outputs 0; cmd_ready=1 first cycle after rst drops.
//  2. pos=0, cmd 3 -> motor_up high 24 cycles, 3 motor_step pulses 8 cycles apart, pos=3, done pulses 4 cycles after MOVE ends.
//  3. pos=3, cmd 3 -> done high the next cycle, busy stays 0, no motor outputs.
//  4. pos=15, cmd 0 -> motor_down high 120 cycles, 15 steps, pos=0 with no wrap, one done pulse; cmd_valid=1 with cmd 7 mid-move -> cmd_ready=0, ignored.
//  5. pos=0, cmd 10, rst at cycle 20 of MOVE -> next cycle pos=0, motors 0, IDLE, no done pulse.
//  6. SHADE_LIMIT_SW_EN, pos=5, cmd 0, lim_bottom=1 at cycle 10 -> pos=0, SETTLE, lim_hit=1, done after 4 cycles; next accepted cmd clears lim_hit.

Source files
------------

// File: rtl/shade_pkg.sv
// Shared definitions for the shade-level interface: level width, end-stop
// levels and the IDLE/MOVE/SETTLE state encoding used by the shade-degree logic.
package shade_pkg;

    localparam int SHADE_W = 4;

    localparam logic [SHADE_W-1:0] SHADE_OPEN   = 4'h0;
    localparam logic [SHADE_W-1:0] SHADE_CLOSED = 4'hF;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MOVE   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_MOVE   = MOVE,
        S_SETTLE = SETTLE
    } shade_state_e;

    // One level toward closed (up) or toward open (down).
    function automatic logic [SHADE_W-1:0] shade_step(input logic [SHADE_W-1:0] lvl,
                                                      input logic up);
        return up ? lvl + 4'd1 : lvl - 4'd1;
    endfunction

endpackage

// File: rtl/shade_step_timer.sv
// Loadable down-counter with terminal-count flag. Used by the actuator for
// both the per-level motor drive time and the post-move settle dwell.
module shade_step_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/window_shade_actuator.sv
// Shade motor actuator: accepts a target level (0 open .. 15 closed) and
// steps the motor one level at a time until the tracked position matches,
// then dwells with motors off before signalling done.
// Optional build macro SHADE_LIMIT_SW_EN adds end-stop limit switch inputs
// that snap the position to the end stop and abort the move.
module window_shade_actuator
    import shade_pkg::*;
#(
    parameter int STEPS_PER_LEVEL = 8,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [SHADE_W-1:0] cmd_level,
    output logic               cmd_ready,
    output logic [SHADE_W-1:0] pos,
    output logic               busy,
    output logic               done,
    output logic               motor_up,
    output logic               motor_down,
`ifdef SHADE_LIMIT_SW_EN
    input  logic               lim_top,
    input  logic               lim_bottom,
    output logic               lim_hit,
`endif
    output logic               motor_step
);

    localparam int TMR_MAX = (STEPS_PER_LEVEL > SETTLE_CYCLES) ? STEPS_PER_LEVEL : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] STEP_LOAD   = TMR_W'(STEPS_PER_LEVEL - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    shade_state_e       state, state_nx;
    logic [SHADE_W-1:0] pos_nx;
    logic [SHADE_W-1:0] target, target_nx;
    logic               dir, dir_nx;
    logic               done_nx;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_tc;
    logic               step_now;
`ifdef SHADE_LIMIT_SW_EN
    logic               lim_hit_nx;
    logic               lim_stop;
`endif

    // One timer serves both phases: reloaded per level in MOVE, once for SETTLE.
    shade_step_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

`ifdef SHADE_LIMIT_SW_EN
    assign lim_stop = (state == S_MOVE) && ((dir && lim_top) || (!dir && lim_bottom));
    assign step_now = (state == S_MOVE) && tmr_tc && !lim_stop;
`else
    assign step_now = (state == S_MOVE) && tmr_tc;
`endif

    assign cmd_ready  = (state == S_IDLE) && !rst;
    assign busy       = (state != S_IDLE);
    assign motor_up   = (state == S_MOVE) && dir && !rst;
    assign motor_down = (state == S_MOVE) && !dir && !rst;
    assign motor_step = step_now && !rst;

    // Next-state, position update and timer control.
    always_comb begin
        state_nx  = state;
        pos_nx    = pos;
        target_nx = target;
        dir_nx    = dir;
        done_nx   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = STEP_LOAD;
`ifdef SHADE_LIMIT_SW_EN
        lim_hit_nx = lim_hit;
`endif
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    target_nx = cmd_level;
                    dir_nx    = (cmd_level > pos);
`ifdef SHADE_LIMIT_SW_EN
                    lim_hit_nx = 1'b0;
`endif
                    if (cmd_level == pos) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = S_MOVE;
                        tmr_load = 1'b1;
                        tmr_val  = STEP_LOAD;
                    end
                end
            end
            S_MOVE: begin
`ifdef SHADE_LIMIT_SW_EN
                if (lim_stop) begin
                    // End stop reached: trust the switch over the step count.
                    pos_nx     = dir ? SHADE_CLOSED : SHADE_OPEN;
                    state_nx   = S_SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LOAD;
                    lim_hit_nx = 1'b1;
                end else
`endif
                if (tmr_tc) begin
                    pos_nx   = shade_step(pos, dir);
                    tmr_load = 1'b1;
                    if (pos_nx == target) begin
                        state_nx = S_SETTLE;
                        tmr_val  = SETTLE_LOAD;
                    end else begin
                        tmr_val  = STEP_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                if (tmr_tc) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and tracked-position registers; reset re-homes the shade as open.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pos    <= SHADE_OPEN;
            target <= SHADE_OPEN;
            dir    <= 1'b0;
            done   <= 1'b0;
`ifdef SHADE_LIMIT_SW_EN
            lim_hit <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            pos    <= pos_nx;
            target <= target_nx;
            dir    <= dir_nx;
            done   <= done_nx;
`ifdef SHADE_LIMIT_SW_EN
            lim_hit <= lim_hit_nx;
`endif
        end
    end

endmodule

// File: tb/tb_window_shade_actuator.sv
// Directed bench for window_shade_actuator (STEPS_PER_LEVEL=8, SETTLE_CYCLES=4).
// Limit-switch scenario is built only when SHADE_LIMIT_SW_EN is defined.
module tb_window_shade_actuator;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [3:0] cmd_level;
    logic       cmd_ready;
    logic [3:0] pos;
    logic       busy;
    logic       done;
    logic       motor_up;
    logic       motor_down;
    logic       motor_step;
`ifdef SHADE_LIMIT_SW_EN
    logic       lim_top;
    logic       lim_bottom;
    logic       lim_hit;
`endif

    int checks = 0;
    int errors = 0;

    window_shade_actuator #(
        .STEPS_PER_LEVEL (8),
        .SETTLE_CYCLES   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_level  (cmd_level),
        .cmd_ready  (cmd_ready),
        .pos        (pos),
        .busy       (busy),
        .done       (done),
        .motor_up   (motor_up),
        .motor_down (motor_down),
`ifdef SHADE_LIMIT_SW_EN
        .lim_top    (lim_top),
        .lim_bottom (lim_bottom),
        .lim_hit    (lim_hit),
`endif
        .motor_step (motor_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command for a single accept edge.
    task automatic send(input logic [3:0] lvl);
        cmd_valid = 1'b1;
        cmd_level = lvl;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for done with a cycle budget; an expired budget is a failed check.
    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(done), 1);
        tick();
    endtask

    initial begin
        int up_cyc, dn_cyc, steps, first_step, last_step, done_at, done_cnt;
        int mono_bad;
        logic [3:0] prev_pos;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_level = 4'd0;
`ifdef SHADE_LIMIT_SW_EN
        lim_top    = 1'b0;
        lim_bottom = 1'b0;
`endif

        // 1. reset held 3 cycles
        repeat (3) tick();
        check("rst_pos", int'(pos), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_motors", int'({motor_up, motor_down, motor_step}), 0);
        check("rst_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(cmd_ready), 1);

        // 2. 0 -> 3
        send(4'd3);
        up_cyc = 0; dn_cyc = 0; steps = 0; first_step = -1; last_step = -1; done_at = -1;
        for (int i = 0; i < 60; i++) begin
            if (motor_up) up_cyc++;
            if (motor_down) dn_cyc++;
            if (motor_step) begin
                steps++;
                if (first_step < 0) first_step = i;
                last_step = i;
            end
            if (done) begin
                done_at = i;
                break;
            end
            tick();
        end
        check("up3_up_cycles", up_cyc, 24);
        check("up3_down_cycles", dn_cyc, 0);
        check("up3_steps", steps, 3);
        check("up3_first_step", first_step, 7);
        check("up3_last_step", last_step, 23);
        check("up3_done_at", done_at, 28);
        check("up3_pos", int'(pos), 3);
        tick();
        check("up3_done_one_cycle", int'(done), 0);
        check("up3_idle", int'(busy), 0);

        // 3. same level
        send(4'd3);
        check("same_done", int'(done), 1);
        check("same_busy", int'(busy), 0);
        check("same_motors", int'({motor_up, motor_down, motor_step}), 0);
        tick();
        check("same_done_clear", int'(done), 0);

        // 4. 3 -> 15, then 15 -> 0 with an ignored command mid-move
        send(4'd15);
        wait_done("to15_done", 200);
        check("to15_pos", int'(pos), 15);
        send(4'd0);
        up_cyc = 0; dn_cyc = 0; steps = 0; done_at = -1; done_cnt = 0; mono_bad = 0;
        prev_pos = pos;
        for (int i = 0; i < 200; i++) begin
            if (i == 30) begin
                cmd_valid = 1'b1;
                cmd_level = 4'd7;
                check("busy_ready_low", int'(cmd_ready), 0);
            end
            if (i == 31) cmd_valid = 1'b0;
            if (motor_up) up_cyc++;
            if (motor_down) dn_cyc++;
            if (motor_step) steps++;
            if (pos > prev_pos) mono_bad++;
            prev_pos = pos;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (done_at >= 0 && i >= done_at + 6) break;
            tick();
        end
        check("dn15_down_cycles", dn_cyc, 120);
        check("dn15_up_cycles", up_cyc, 0);
        check("dn15_steps", steps, 15);
        check("dn15_done_at", done_at, 124);
        check("dn15_done_count", done_cnt, 1);
        check("dn15_no_wrap", mono_bad, 0);
        check("dn15_pos", int'(pos), 0);
        check("dn15_ignored_cmd", int'(busy), 0);

        // 5. reset in the middle of a move
        send(4'd10);
        repeat (20) tick();
        check("mid_pos_before_rst", int'(pos), 2);
        check("mid_up_before_rst", int'(motor_up), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_pos", int'(pos), 0);
        check("mid_rst_motors", int'({motor_up, motor_down, motor_step}), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_pos_hold", int'(pos), 0);

`ifdef SHADE_LIMIT_SW_EN
        // 6. limit switch during a downward move
        send(4'd5);
        wait_done("to5_done", 100);
        check("to5_pos", int'(pos), 5);
        send(4'd0);
        repeat (10) tick();
        check("lim_pos_before", int'(pos), 4);
        lim_bottom = 1'b1;
        tick();
        lim_bottom = 1'b0;
        check("lim_pos", int'(pos), 0);
        check("lim_busy", int'(busy), 1);
        check("lim_motors_off", int'({motor_up, motor_down}), 0);
        check("lim_hit_set", int'(lim_hit), 1);
        repeat (4) tick();
        check("lim_done", int'(done), 1);
        check("lim_hit_sticky", int'(lim_hit), 1);
        tick();
        send(4'd2);
        check("lim_hit_cleared", int'(lim_hit), 0);
        wait_done("lim_next_done", 100);
        check("lim_next_pos", int'(pos), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
